gray_monitor: RTL and testbench
===============================

# gray_monitor

- Downstream consumer of the 3-bit Gray-code counter stage.
- Samples the Gray stream whenever the producer is enabled, converts each code to binary and checks that each new code is exactly one legal step from the previous one.
- Counts wrap-arounds and latches a sticky fault on any illegal transition.
- Feeds the checked binary value and status to the rest of the datapath.

## Interface
- WIDTH, 3, width of the Gray code and the binary output
- CNT_WIDTH, 8, width of the wrap counter
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low: state is cleared at a rising Clk edge while Reset is 0
- En  in  1  sample strobe; Gray is valid this cycle
- Gray  in  WIDTH  Gray code from the upstream counter
- Clear  in  1  synchronous soft clear, active-high
- Binary  out  WIDTH  registered binary of the last accepted sample
- Step  out  1  one-cycle pulse: last sample was a legal +1 step
- Wrap  out  1  one-cycle pulse: last sample was the max→0 step
- Error  out  1  sticky illegal-transition flag
- WrapCount  out  CNT_WIDTH  saturating count of wrap steps
- State  out  2  FSM state: 00 EMPTY, 01 TRACK, 10 FAULT

## Operation
- Conversion: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i]. All arithmetic is modulo 2^WIDTH.
- Internal register prev holds the binary value of the last accepted sample.
- **EMPTY**
  - On En: accept the sample, prev/Binary ← conv(Gray), go to TRACK.
  - No Step, no Wrap, no check on this first sample.
- **TRACK**, on En, with cur = conv(Gray):
  - cur == prev: repeat. No pulse, no error, stay in TRACK.
  - cur == prev+1 mod 2^W: Step=1, prev/Binary ← cur.
    - If prev == 2^W-1 (so cur == 0), also Wrap=1 and WrapCount++.
    - WrapCount saturates at 2^CNT_WIDTH-1.
  - Anything else (decrement, skip, multi-bit Gray change): Error ← 1, go to FAULT.
    - Binary and prev keep the last good value.
    - No Step or Wrap pulse.
- **FAULT**
  - Samples are ignored.
  - Error stays 1; Binary and WrapCount hold.
  - Only Clear or Reset leave this state.
- **Clear = 1** (any state): go to EMPTY; Error, Binary, prev, WrapCount ← 0; Step and Wrap stay 0.
- **Priority:** Reset (low) > Clear > En. A sample arriving with Clear is discarded.
- **En = 0:** nothing changes except Step and Wrap, which return to 0.

## Timing
- Reset values (Reset = 0 at an edge):
  - State = EMPTY (00).
  - Binary, Step, Wrap, Error, WrapCount and prev = 0.
- All outputs are registered. A sample presented with En at edge k is reflected on Binary/Step/Wrap/Error/State after edge k, i.e. 1-cycle latency.
- Step and Wrap are high for exactly one cycle per qualifying sample.
- Back-to-back En every cycle is supported at full rate.
- Reset or Clear in mid-stream takes effect at that edge. The next En sample is treated as a first sample with no check.
- Error rises at the edge that accepts the bad sample and stays high in the cycles that follow.

## Test plan
- **Full cycle** (WIDTH=3, reset released, En every cycle)
  - Stimulus: Gray 000,001,011,010,110,111,101,100,000.
  - Required: Binary 0,1,2,3,4,5,6,7,0.
  - Required: 8 Step pulses (none for the first sample); a single Wrap pulse, on the 100→000 step.
  - Required: WrapCount=1, Error=0, State=01.
- **Illegal skip**
  - Stimulus: Gray 001 then 010 (binary 1→3).
  - Required: Error=1 and State=10 after the second edge; Binary stays 1.
  - Required: further samples (e.g. 011) change nothing.
  - Then: Clear=1 for one cycle → State=00, Error=0, WrapCount=0.
- **Repeat and backward step**
  - Stimulus: Gray 011, 011 (repeat).
  - Required: no Step pulse, Error=0.
  - Then: Gray 001 (binary 2→1).
  - Required: Error=1, State=10.
- **Clear with En in the same cycle**
  - Stimulus: in TRACK at Binary=5, Clear=1 and En=1 with Gray=100.
  - Required: State=00, Binary=0; the sample is discarded.
  - Then: next En with Gray=110 → Binary=4, no Step pulse, State=01.
- **Reset mid-operation and saturation** (CNT_WIDTH=2)
  - Stimulus: drive 5 full cycles.
  - Required: WrapCount holds at 3.
  - Then: Reset=0 for one edge.
  - Required: all outputs 0 and State=00 after that edge; Reset=1 restores normal sampling.

Source files
------------

// File: rtl/gray_monitor.sv
// gray_monitor: checks a Gray-code stream for legal +1 steps, counts wraps, latches faults
module gray_monitor #(
  parameter int WIDTH     = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [WIDTH-1:0]     Gray,
  input  logic                 Clear,
  output logic [WIDTH-1:0]     Binary,
  output logic                 Step,
  output logic                 Wrap,
  output logic                 Error,
  output logic [CNT_WIDTH-1:0] WrapCount,
  output logic [1:0]           State
);
  typedef enum logic [1:0] {EMPTY = 2'b00, TRACK = 2'b01, FAULT = 2'b10} state_t;
  state_t st;
  logic [WIDTH-1:0] cur, nxt;
  assign State = st;
  assign nxt = Binary + 1'b1;
  // Binary bit i is the XOR of all Gray bits at or above i
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign cur[i] = ^(Gray >> i);
  end
  // Binary doubles as the last accepted value, so no separate prev register
  always_ff @(posedge Clk) begin
    if (!Reset || Clear) begin
      st        <= EMPTY;
      Binary    <= '0;
      Step      <= 1'b0;
      Wrap      <= 1'b0;
      Error     <= 1'b0;
      WrapCount <= '0;
    end else begin
      Step <= 1'b0;
      Wrap <= 1'b0;
      if (En) begin
        case (st)
          EMPTY: begin
            Binary <= cur;
            st     <= TRACK;
          end
          TRACK: begin
            if (cur == nxt) begin
              Binary <= cur;
              Step   <= 1'b1;
              if (&Binary) begin
                Wrap <= 1'b1;
                if (!(&WrapCount)) WrapCount <= WrapCount + 1'b1;
              end
            end else if (cur != Binary) begin
              Error <= 1'b1;
              st    <= FAULT;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor: directed vectors against the default monitor and a 2-bit-counter variant
module tb_gray_monitor;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b0;
  logic       Clear = 1'b0;
  logic [2:0] Gray = 3'b000;
  logic [2:0] Binary, b2;
  logic       Step, Wrap, Error, s2, w2, e2;
  logic [7:0] WrapCount;
  logic [1:0] wc2, State, st2;
  int total = 0;
  int bad = 0;
  int steps, wraps;

  gray_monitor dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray), .Clear(Clear),
    .Binary(Binary), .Step(Step), .Wrap(Wrap), .Error(Error),
    .WrapCount(WrapCount), .State(State)
  );

  gray_monitor #(.WIDTH(3), .CNT_WIDTH(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .En(En), .Gray(Gray), .Clear(Clear),
    .Binary(b2), .Step(s2), .Wrap(w2), .Error(e2),
    .WrapCount(wc2), .State(st2)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [2:0] g);
    Gray = g;
    En = 1'b1;
    tick();
  endtask

  task automatic idle();
    En = 1'b0;
    tick();
  endtask

  initial begin
    logic [2:0] seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    tick();
    tick();
    chk("rst_state", State, 0);
    chk("rst_bin", Binary, 0);
    chk("rst_step", Step, 0);
    chk("rst_wrap", Wrap, 0);
    chk("rst_err", Error, 0);
    chk("rst_wc", WrapCount, 0);
    Reset = 1'b1;
    tick();
    chk("idle_state", State, 0);

    steps = 0;
    wraps = 0;
    for (int k = 0; k < 9; k++) begin
      send(seq[k]);
      chk("full_bin", Binary, k % 8);
      chk("full_step", Step, k > 0);
      chk("full_wrap", Wrap, k == 8);
      steps += Step;
      wraps += Wrap;
    end
    chk("full_steps", steps, 8);
    chk("full_wraps", wraps, 1);
    chk("full_wc", WrapCount, 1);
    chk("full_wc2", wc2, 1);
    chk("full_err", Error, 0);
    chk("full_state", State, 1);
    idle();
    chk("noen_step", Step, 0);
    chk("noen_bin", Binary, 0);

    send(3'b001);
    chk("skip_first_bin", Binary, 1);
    send(3'b010);
    chk("skip_err", Error, 1);
    chk("skip_state", State, 2);
    chk("skip_bin", Binary, 1);
    chk("skip_step", Step, 0);
    send(3'b011);
    chk("fault_bin", Binary, 1);
    chk("fault_state", State, 2);
    chk("fault_err", Error, 1);
    chk("fault_step", Step, 0);
    chk("fault_wc", WrapCount, 1);
    En = 1'b0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_state", State, 0);
    chk("clr_err", Error, 0);
    chk("clr_wc", WrapCount, 0);
    chk("clr_bin", Binary, 0);

    send(3'b011);
    chk("rep_first_bin", Binary, 2);
    chk("rep_first_step", Step, 0);
    chk("rep_first_state", State, 1);
    send(3'b011);
    chk("rep_step", Step, 0);
    chk("rep_err", Error, 0);
    chk("rep_bin", Binary, 2);
    send(3'b001);
    chk("back_err", Error, 1);
    chk("back_state", State, 2);
    chk("back_bin", Binary, 2);

    En = 1'b0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    send(3'b111);
    chk("ce_pre_bin", Binary, 5);
    Clear = 1'b1;
    send(3'b100);
    Clear = 1'b0;
    chk("ce_state", State, 0);
    chk("ce_bin", Binary, 0);
    chk("ce_step", Step, 0);
    send(3'b110);
    chk("ce_next_bin", Binary, 4);
    chk("ce_next_step", Step, 0);
    chk("ce_next_state", State, 1);

    En = 1'b0;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    send(3'b000);
    for (int c = 0; c < 5; c++)
      for (int k = 1; k < 9; k++) send(seq[k]);
    chk("sat_wc2", wc2, 3);
    chk("sat_wc", WrapCount, 5);
    chk("sat_wrap2", w2, 1);
    chk("sat_err2", e2, 0);
    chk("sat_state2", st2, 1);
    En = 1'b0;
    Reset = 1'b0;
    tick();
    chk("mrst_state", State, 0);
    chk("mrst_bin", Binary, 0);
    chk("mrst_wc", WrapCount, 0);
    chk("mrst_wc2", wc2, 0);
    chk("mrst_step", Step, 0);
    chk("mrst_wrap", Wrap, 0);
    chk("mrst_err", Error, 0);
    chk("mrst_state2", st2, 0);
    chk("mrst_bin2", b2, 0);
    chk("mrst_step2", s2, 0);
    Reset = 1'b1;
    send(3'b010);
    chk("post_bin", Binary, 3);
    chk("post_step", Step, 0);
    chk("post_state", State, 1);
    send(3'b110);
    chk("post_step2", Step, 1);
    chk("post_bin2", Binary, 4);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
